// File: rtl/sequencer_tempo_gen.sv
// -----------------------------------------------------------------------------
// sequencer_tempo_gen
//
// Programmable tempo and step generator for the step sequencer. The system
// clock is divided by a runtime-programmable beat period to give a one-cycle
// beat strobe. The module also tracks the step currently playing within a
// programmable-length pattern and flags each bar boundary.
//
// Optional feature macro: SWING_EN
//   Defined   : alternate beat intervals are lengthened and shortened by a
//               swing offset S = min(swing_amt, P/2).
//   Undefined : every interval is exactly P cycles and swing_amt is ignored.
//
// Ports
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   sequencer_on  run enable; low = stopped and cleared
//   period_in     requested beat period in clk cycles (clamped to >= 2)
//   num_steps     pattern length minus one
//   swing_amt     swing offset in cycles (used only with SWING_EN)
//   beat_pulse    one-cycle strobe at the end of each beat interval
//   bar_pulse     one-cycle strobe on the beat that wraps step_idx to 0
//   step_idx      index of the step currently playing
// -----------------------------------------------------------------------------
module sequencer_tempo_gen #(
    parameter int CNT_W      = 24,
    parameter int STEP_W     = 4,
    parameter int DEF_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sequencer_on,
    input  logic [CNT_W-1:0]  period_in,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [CNT_W-2:0]  swing_amt,
    output logic              beat_pulse,
    output logic              bar_pulse,
    output logic [STEP_W-1:0] step_idx
);

    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(2);
    localparam logic [CNT_W:0]   ONE_EXT = (CNT_W+1)'(1);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  period_nxt;
    logic [STEP_W-1:0] len_q;
    logic [CNT_W:0]    interval_m1;   // T-1, one bit wider so P+S cannot wrap
    logic              load_p;

    // Period and length are only sampled while stopped or at a beat/bar
    // boundary, so a change never lands in the middle of an interval.
    assign period_nxt = (period_in < MIN_P) ? MIN_P : period_in;
    assign load_p     = !sequencer_on || beat_pulse;

`ifdef SWING_EN
    logic [CNT_W-1:0] swing_q;
    logic [CNT_W-1:0] swing_nxt;
    logic [CNT_W-1:0] swing_ext;
    logic [CNT_W-1:0] half_p;

    // S is derived from the period being loaded, so it stays consistent
    // with P and keeps each pair of steps at exactly 2P.
    assign swing_ext = {1'b0, swing_amt};
    assign half_p    = period_nxt >> 1;
    assign swing_nxt = (swing_ext < half_p) ? swing_ext : half_p;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            swing_q <= '0;
        end else if (load_p) begin
            swing_q <= swing_nxt;
        end
    end

    // Even steps play long (P+S), odd steps play short (P-S).
    always_comb begin
        interval_m1 = '0;
        if (step_idx[0]) begin
            interval_m1 = {1'b0, period_q} - {1'b0, swing_q} - ONE_EXT;
        end else begin
            interval_m1 = {1'b0, period_q} + {1'b0, swing_q} - ONE_EXT;
        end
    end
`else
    logic swing_unused;
    assign swing_unused = ^swing_amt;

    always_comb begin
        interval_m1 = {1'b0, period_q} - ONE_EXT;
    end
`endif

    assign beat_pulse = sequencer_on && ({1'b0, count} == interval_m1);
    // ">=" also recovers cleanly if the step index ever sits beyond the length.
    assign bar_pulse  = beat_pulse && (step_idx >= len_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count    <= '0;
            step_idx <= '0;
            period_q <= DEF_P;
            len_q    <= '0;
        end else begin
            if (!sequencer_on || beat_pulse) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end

            if (!sequencer_on) begin
                step_idx <= '0;
            end else if (beat_pulse) begin
                step_idx <= bar_pulse ? '0 : step_idx + STEP_W'(1);
            end

            if (load_p) begin
                period_q <= period_nxt;
            end

            if (!sequencer_on || bar_pulse) begin
                len_q <= num_steps;
            end
        end
    end

endmodule

// File: tb/tb_sequencer_tempo_gen.sv
module tb_sequencer_tempo_gen;

    localparam int CNT_W  = 24;
    localparam int STEP_W = 4;
    localparam int DEF_P  = 20;

    logic              clk;
    logic              n_rst;
    logic              sequencer_on;
    logic [CNT_W-1:0]  period_in;
    logic [STEP_W-1:0] num_steps;
    logic [CNT_W-2:0]  swing_amt;
    logic              beat_pulse;
    logic              bar_pulse;
    logic [STEP_W-1:0] step_idx;

    sequencer_tempo_gen #(
        .CNT_W(CNT_W),
        .STEP_W(STEP_W),
        .DEF_PERIOD(DEF_P)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .sequencer_on(sequencer_on),
        .period_in(period_in),
        .num_steps(num_steps),
        .swing_amt(swing_amt),
        .beat_pulse(beat_pulse),
        .bar_pulse(bar_pulse),
        .step_idx(step_idx)
    );

    typedef struct {
        int cyc;
        int step;
        bit bar;
    } beat_t;

    beat_t exp_q[$];
    int    cyc;
    int    checks;
    int    errors;
    int    c0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int s, input bit b);
        beat_t e;
        e.cyc  = c;
        e.step = s;
        e.bar  = b;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops an expected beat whenever the DUT strobes, flags
    // unexpected and missing strobes.
    always @(negedge clk) begin
        beat_t e;
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_beat actual=none required=cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (beat_pulse) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=cycle %0d step %0d required=no beat",
                         cyc, step_idx);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || int'(step_idx) != e.step || bar_pulse != e.bar) begin
                    errors++;
                    $display("FAIL beat actual=cyc %0d step %0d bar %0b required=cyc %0d step %0d bar %0b",
                             cyc, step_idx, bar_pulse, e.cyc, e.step, e.bar);
                end
            end
        end else if (bar_pulse) begin
            checks++;
            errors++;
            $display("FAIL bar_without_beat actual=bar 1 required=bar 0 at cycle %0d", cyc);
        end
    end

    task automatic stop_and_settle();
        sequencer_on = 1'b0;
        repeat (2) next_cycle();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        n_rst        = 1'b0;
        sequencer_on = 1'b1;
        period_in    = 10;
        num_steps    = 0;
        swing_amt    = '0;

        // Reset state, running straight out of reset on the default period.
        #3;
        check_val("rst_step_idx", step_idx, 0);
        check_val("rst_beat", beat_pulse, 0);
        check_val("rst_bar", bar_pulse, 0);
        repeat (2) next_cycle();
        n_rst = 1'b1;
        c0 = cyc;
        push(c0 + 19, 0, 1'b1);   // default period, default length 0
        num_steps = 3;
        push(c0 + 29, 0, 1'b0);   // period_in=10 and length 3 picked up at bar
        wait_to(c0 + 30);
        stop_and_settle();

        // Test 1: P=10, 4 steps.
        period_in = 10;
        num_steps = 3;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 9, 0, 1'b0);
        push(c0 + 19, 1, 1'b0);
        push(c0 + 29, 2, 1'b0);
        push(c0 + 39, 3, 1'b1);
        wait_to(c0 + 40);
        stop_and_settle();

        // Test 2: period 0 and 1 clamp to 2.
        for (int k = 0; k < 2; k++) begin
            period_in = k;
            num_steps = 1;
            next_cycle();
            sequencer_on = 1'b1;
            c0 = cyc;
            push(c0 + 1, 0, 1'b0);
            push(c0 + 3, 1, 1'b1);
            push(c0 + 5, 0, 1'b0);
            push(c0 + 7, 1, 1'b1);
            wait_to(c0 + 8);
            stop_and_settle();
        end

        // Test 3: period change mid-interval takes effect at the beat.
        period_in = 10;
        num_steps = 15;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 9, 0, 1'b0);
        push(c0 + 13, 1, 1'b0);
        push(c0 + 17, 2, 1'b0);
        push(c0 + 21, 3, 1'b0);
        wait_to(c0 + 5);
        period_in = 4;
        wait_to(c0 + 22);
        stop_and_settle();

        // Test 4: abort at count 6, restart 3 cycles later.
        period_in = 10;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        wait_to(c0 + 6);
        sequencer_on = 1'b0;
        wait_to(c0 + 8);
        check_val("abort_step_idx", step_idx, 0);
        wait_to(c0 + 9);
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 9, 0, 1'b0);
        push(c0 + 19, 1, 1'b0);
        wait_to(c0 + 20);
        stop_and_settle();

        // Test 5: length shrink while running waits for the next bar.
        period_in = 4;
        num_steps = 7;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 8; k++) push(c0 + 3 + 4 * k, k, k == 7);
        wait_to(c0 + 20);
        check_val("len_step_before_change", step_idx, 5);
        num_steps = 1;
        push(c0 + 35, 0, 1'b0);
        push(c0 + 39, 1, 1'b1);
        push(c0 + 43, 0, 1'b0);
        wait_to(c0 + 44);
        stop_and_settle();

        // Async reset mid-operation.
        period_in = 10;
        num_steps = 3;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 9, 0, 1'b0);
        wait_to(c0 + 15);
        check_val("pre_reset_step_idx", step_idx, 1);
        #2;
        n_rst = 1'b0;
        sequencer_on = 1'b0;
        #1;
        check_val("async_rst_step_idx", step_idx, 0);
        check_val("async_rst_beat", beat_pulse, 0);
        next_cycle();
        n_rst = 1'b1;
        next_cycle();

`ifdef SWING_EN
        // Test 6: swing 3, then swing 9 clamped to P/2 = 5.
        period_in = 10;
        num_steps = 15;
        swing_amt = 3;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 12, 0, 1'b0);
        push(c0 + 19, 1, 1'b0);
        push(c0 + 32, 2, 1'b0);
        push(c0 + 39, 3, 1'b0);
        wait_to(c0 + 40);
        stop_and_settle();
        swing_amt = 9;
        next_cycle();
        sequencer_on = 1'b1;
        c0 = cyc;
        push(c0 + 14, 0, 1'b0);
        push(c0 + 19, 1, 1'b0);
        push(c0 + 34, 2, 1'b0);
        push(c0 + 39, 3, 1'b0);
        wait_to(c0 + 40);
        stop_and_settle();
`endif

        repeat (5) next_cycle();
        check_val("pending_beats", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
